// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM
// state encoding, exception causes and small op-classification helpers.
package mem_lsu_ctrl_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Exception cause codes
    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWaitR = 2'd2,
        StDone  = 2'd3
    } lsu_state_e;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic is_valid_op(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for the
// outgoing bus word, and byte/half extraction with extension for loads.
module mem_lsu_align
    import mem_lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane;

    // Shift the addressed byte/half down to bit 0
    assign lane = rdata_i >> {off_i, 3'b000};

    // Store lane replication and byte enables
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        unique case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load extension
    always_comb begin
        ld_data_o = rdata_i;
        unique case (funct3_i)
            F3_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   ld_data_o = {24'h0, lane[7:0]};
            F3_HU:   ld_data_o = {16'h0, lane[15:0]};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store sequencer: runs a req/gnt/rvalid bus handshake for one
// op per instruction, stalls the pipeline until done, and reports misaligned
// and bus-timeout exceptions.
module mem_lsu_ctrl
    import mem_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic        exc_o,
    output logic [3:0]  exc_cause_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i
);

    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kill_q, kill_d;
    logic             to_q, to_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [29:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      ld_data_q;
    logic             latch, ld_cap;

    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld_data;

    logic op_ok, op_mis, tmo;

    assign op_ok  = is_valid_op(mem_we_i, mem_funct3_i);
    assign op_mis = is_misaligned(mem_funct3_i, mem_addr_i[1:0]);
    assign tmo    = (cnt_q >= TmoLast);

    // Incoming op drives the lane logic in IDLE; afterwards the latched op does
    assign al_funct3 = (state_q == StIdle) ? mem_funct3_i : funct3_q;
    assign al_off    = (state_q == StIdle) ? mem_addr_i[1:0] : off_q;

    mem_lsu_align u_align (
        .funct3_i  (al_funct3),
        .off_i     (al_off),
        .wdata_i   (mem_wdata_i),
        .rdata_i   (dbus_rdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld_data)
    );

    // FSM next state and handshake/pipeline outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        to_d        = to_q;
        latch       = 1'b0;
        ld_cap      = 1'b0;
        stallreq_o  = 1'b0;
        ld_valid_o  = 1'b0;
        exc_o       = 1'b0;
        exc_cause_o = 4'h0;
        dbus_req_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // rst gating keeps outputs quiet while reset is held
                if (rst && mem_req_i && !flush_i && op_ok) begin
                    if (op_mis) begin
                        exc_o       = 1'b1;
                        exc_cause_o = mem_we_i ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                    end else begin
                        stallreq_o = 1'b1;
                        latch      = 1'b1;
                        cnt_d      = '0;
                        kill_d     = 1'b0;
                        to_d       = 1'b0;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                stallreq_o = 1'b1;
                dbus_req_o = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (dbus_gnt_i) begin
                    if (flush_i) begin
                        kill_d = 1'b1;
                    end
                    state_d = we_q ? StDone : StWaitR;
                end else if (flush_i) begin
                    state_d = StIdle;
                end else if (tmo) begin
                    to_d    = 1'b1;
                    state_d = StDone;
                end
            end
            StWaitR: begin
                stallreq_o = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (dbus_rvalid_i) begin
                    ld_cap  = 1'b1;
                    state_d = StDone;
                end else if (tmo) begin
                    to_d    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!kill_q && !flush_i) begin
                    if (to_q) begin
                        exc_o       = 1'b1;
                        exc_cause_o = we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    end else if (!we_q) begin
                        ld_valid_o = 1'b1;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus signals come from the latched op and are zero outside REQ
    assign dbus_we_o    = dbus_req_o & we_q;
    assign dbus_addr_o  = dbus_req_o ? {addr_q, 2'b00} : 32'h0;
    assign dbus_be_o    = dbus_req_o ? be_q : 4'h0;
    assign dbus_wdata_o = dbus_req_o ? wdata_q : 32'h0;
    assign ld_data_o    = ld_valid_o ? ld_data_q : 32'h0;

    // FSM state, timeout counter and kill/timeout flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            to_q    <= to_d;
        end
    end

    // Op latch on acceptance and load-data capture on rvalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            funct3_q  <= 3'h0;
            off_q     <= 2'h0;
            addr_q    <= 30'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            ld_data_q <= 32'h0;
        end else begin
            if (latch) begin
                we_q     <= mem_we_i;
                funct3_q <= mem_funct3_i;
                off_q    <= mem_addr_i[1:0];
                addr_q   <= mem_addr_i[31:2];
                be_q     <= al_be;
                wdata_q  <= al_wdata;
            end
            if (ld_cap) begin
                ld_data_q <= al_ld_data;
            end
        end
    end

endmodule

// File: doc/mem_lsu_ctrl.md
Name: mem_lsu_ctrl

Overview:
- Load/store sequencer for the MEM stage.
- Takes one memory op per instruction from the EX/MEM register and runs a req/gnt/rvalid handshake on the data bus.
- Generates byte enables and lane-replicated store data, and sign/zero-extends load data.
- Holds the pipeline via stallreq_o until the access completes; reports misaligned and bus-timeout exceptions.

Parameters:
- TIMEOUT_CYC, 16: cycles spent in REQ+WAIT_R before a bus error is declared.
- CNT_W, 5: timeout counter width; must be large enough that TIMEOUT_CYC fits.

Ports:
- clk  in  1: core clock
- rst  in  1: asynchronous, active-low reset
- mem_req_i  in  1: valid memory op in MEM stage
- mem_we_i  in  1: 1 = store, 0 = load
- mem_funct3_i  in  3: LB/LH/LW/LBU/LHU or SB/SH/SW encoding
- mem_addr_i  in  32: byte address
- mem_wdata_i  in  32: store source (rs2)
- flush_i  in  1: kill current op (trap/redirect)
- stallreq_o  out  1: to pipeline ctrl; holds IF..MEM
- ld_valid_o  out  1: one-cycle pulse, ld_data_o valid
- ld_data_o  out  32: extended load result
- exc_o  out  1: one-cycle exception pulse
- exc_cause_o  out  4: 4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
- dbus_req_o  out  1: bus request
- dbus_we_o  out  1: bus write
- dbus_addr_o  out  32: word-aligned address, {addr[31:2],2'b00}
- dbus_be_o  out  4: byte enables
- dbus_wdata_o  out  32: lane-replicated store data
- dbus_gnt_i  in  1: request accepted this cycle
- dbus_rvalid_i  in  1: read data valid
- dbus_rdata_i  in  32: read data

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, kill flag 0; all outputs 0.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, mem_req_i=1 and aligned:
  - Latch we, funct3, addr[1:0], be and wdata.
  - stallreq_o=1 combinationally.
  - Next state REQ.
- IDLE, misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0):
  - No bus access and no stall.
  - exc_o=1 in the same cycle, cause 4 (load) or 6 (store).
  - Remain in IDLE.
- REQ:
  - dbus_req_o=1; address, we, be and wdata are held stable from registers until gnt.
  - gnt with store -> DONE.
  - gnt with load -> WAIT_R.
- WAIT_R:
  - On dbus_rvalid_i, capture the extracted data -> DONE.
  - rvalid arriving in the same cycle as gnt is not accepted; rvalid is sampled only in WAIT_R.
- DONE:
  - stallreq_o=0.
  - Load: ld_valid_o=1 with ld_data_o.
  - Next state IDLE.
  - The pipeline advances at the end of DONE, so IDLE sees the next instruction.
- stallreq_o=1 in REQ and WAIT_R, and in IDLE when accepting an aligned op; 0 otherwise.
- Latency: store min 3 cycles (IDLE, REQ, DONE); load min 4 cycles.
- Byte enables and store data:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{b}}.
  - SH: be = 4'b0011<<addr[1:0]; wdata = {2{h}}.
  - SW: be = 4'b1111.
- Load extraction: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT_R.
  - At TIMEOUT_CYC-1 with no completion: drop dbus_req_o, go to DONE with exc_o=1, cause 5 or 7, ld_valid_o=0.
- flush_i:
  - In IDLE or REQ before gnt: abandon, no bus transaction, next IDLE, no outputs.
  - In REQ with gnt the same cycle, or in WAIT_R: set kill flag. Load still drains rvalid; DONE then suppresses ld_valid_o/exc_o. Store goes to DONE silently.
  - In DONE: result suppressed.
- Stray rvalid in IDLE/REQ/DONE is ignored.
- Undefined funct3 with mem_req_i: treated as a no-op; no stall, no exception.

Decomposition:
- bitty_defs.v gains:
  - funct3 load/store codes
  - LSU state encodings (2-bit)
  - exception cause codes 4–7
- Sub-module mem_lsu_align (combinational): funct3 + addr[1:0] + wdata/rdata -> be, lane-replicated wdata, extended load data.
- The FSM and counter stay in mem_lsu_ctrl.

Test Plan:
- SW addr 0x0000_1004, wdata 0xDEADBEEF, gnt in REQ cycle 1 -> dbus_be 4'b1111, addr 0x1004, stallreq high 2 cycles, DONE on cycle 3, no exc.
- LB addr 0x0000_2003, rdata 0x80FF_FF7F, gnt immediate, rvalid 2 cycles later -> ld_data 0xFFFF_FF80, ld_valid single pulse, total 5 cycles.
- SH addr 0x0000_3001 -> exc_o=1 cause 6 in the same cycle, dbus_req_o never asserted, stallreq_o=0.
- LW addr 0x4000, gnt never asserted -> dbus_req high exactly 16 cycles, then exc_o cause 5, FSM back to IDLE; a late rvalid is ignored.
- LHU addr 0x5002, flush_i in the first WAIT_R cycle, rvalid 3 cycles later -> no ld_valid, no exc; next op accepted normally.
- rst low during WAIT_R -> all outputs 0 immediately; after release, a SB 0x6001 data 0xAB yields be 4'b0010, wdata 0xABABABAB.
